// File: rtl/picobello_boot_seq.sv
// -----------------------------------------------------------------------------
// picobello_boot_seq
// Boot sequencer for the picobello host. After reset it samples the boot and
// preload mode straps, then either waits for an external preload (JTAG / serial
// link / UART) or drives the autonomous image-loader handshake with bounded
// retries. Once the image is in place it releases the core (fetch_en_o) and
// waits for an end-of-computation write to the scratch register, whose upper
// 31 bits become the exit code.
//
// Optional run-phase watchdog: define PICOBELLO_BOOT_SEQ_TIMEOUT_EN to compile
// it in. Without it RUN waits indefinitely and no counter exists.
//
// Parameters:
//   TimeoutCycles  run-phase watchdog limit in cycles (0 disables the watchdog)
//   LoadRetries    loader re-requests allowed after load_err_i before erroring
//
// Ports:
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   boot_mode_i     0 idle/preload, 1 SD card (unsupported), 2/3 autonomous
//   preload_mode_i  0 JTAG, 1 serial link, 2 UART, 3 reserved
//   preload_done_i  host pulse: preload finished
//   load_req_o      loader request, held until load_gnt_i
//   load_gnt_i      loader grant
//   load_done_i     loader finished successfully
//   load_err_i      loader failed (wins over load_done_i)
//   fetch_en_o      releases the host core from reset-fetch hold
//   eoc_valid_i     scratch-register write strobe
//   eoc_data_i      scratch-register write data (bit0 = end-of-computation)
//   done_o          sequence finished (also set on error)
//   err_o           sequence ended in error
//   exit_code_o     exit code of the program or error code
//   state_o         current FSM state encoding
// -----------------------------------------------------------------------------
module picobello_boot_seq #(
  parameter int unsigned TimeoutCycles = 32'd1048576,
  parameter int unsigned LoadRetries   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  boot_mode_i,
  input  logic [1:0]  preload_mode_i,
  input  logic        preload_done_i,
  output logic        load_req_o,
  input  logic        load_gnt_i,
  input  logic        load_done_i,
  input  logic        load_err_i,
  output logic        fetch_en_o,
  input  logic        eoc_valid_i,
  input  logic [31:0] eoc_data_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] exit_code_o,
  output logic [2:0]  state_o
);

  localparam int unsigned RetryW = (LoadRetries > 0) ? $clog2(LoadRetries + 1) : 1;

  localparam logic [31:0] ExitSdUnsup   = 32'hE000_0001;
  localparam logic [31:0] ExitPreRsvd   = 32'hE000_0002;
  localparam logic [31:0] ExitLoadFail  = 32'hE000_0003;
  localparam logic [31:0] ExitTimeout   = 32'hE000_0004;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSample   = 3'd1,
    StWaitPre  = 3'd2,
    StLoad     = 3'd3,
    StLoadWait = 3'd4,
    StRun      = 3'd5,
    StDone     = 3'd6,
    StError    = 3'd7
  } state_e;

  state_e              state_q;
  logic [1:0]          boot_mode_q;
  logic [1:0]          preload_mode_q;
  logic [RetryW-1:0]   retry_q;
  logic                load_req_q;
  logic                fetch_en_q;
  logic                done_q;
  logic                err_q;
  logic [31:0]         exit_code_q;
`ifdef PICOBELLO_BOOT_SEQ_TIMEOUT_EN
  logic [31:0]         wdg_q;
`endif

  // Only writes with bit0 set signal end of computation.
  logic eoc_hit_c;
  assign eoc_hit_c = eoc_valid_i & eoc_data_i[0];

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      boot_mode_q    <= 2'd0;
      preload_mode_q <= 2'd0;
      retry_q        <= '0;
      load_req_q     <= 1'b0;
      fetch_en_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      exit_code_q    <= 32'd0;
`ifdef PICOBELLO_BOOT_SEQ_TIMEOUT_EN
      wdg_q          <= 32'd0;
`endif
    end else begin
      case (state_q)
        StIdle: state_q <= StSample;

        // Straps are latched once here; decision uses the same-cycle values.
        StSample: begin
          boot_mode_q    <= boot_mode_i;
          preload_mode_q <= preload_mode_i;
          if (boot_mode_i == 2'd1) begin
            state_q     <= StError;
            err_q       <= 1'b1;
            done_q      <= 1'b1;
            exit_code_q <= ExitSdUnsup;
          end else if (boot_mode_i == 2'd0 && preload_mode_i == 2'd3) begin
            state_q     <= StError;
            err_q       <= 1'b1;
            done_q      <= 1'b1;
            exit_code_q <= ExitPreRsvd;
          end else if (boot_mode_i == 2'd0) begin
            state_q <= StWaitPre;
          end else begin
            state_q    <= StLoad;
            load_req_q <= 1'b1;
          end
        end

        // Latched straps re-qualify the preload path; reserved mode never gets here.
        StWaitPre: begin
          if (preload_done_i && boot_mode_q == 2'd0 && preload_mode_q != 2'd3) begin
            state_q    <= StRun;
            fetch_en_q <= 1'b1;
`ifdef PICOBELLO_BOOT_SEQ_TIMEOUT_EN
            wdg_q      <= 32'd0;
`endif
          end
        end

        StLoad: begin
          if (load_gnt_i) begin
            state_q    <= StLoadWait;
            load_req_q <= 1'b0;
          end
        end

        // Error takes priority over a simultaneous done.
        StLoadWait: begin
          if (load_err_i) begin
            if (32'(retry_q) < LoadRetries) begin
              retry_q    <= retry_q + RetryW'(1);
              state_q    <= StLoad;
              load_req_q <= 1'b1;
            end else begin
              state_q     <= StError;
              err_q       <= 1'b1;
              done_q      <= 1'b1;
              exit_code_q <= ExitLoadFail;
            end
          end else if (load_done_i) begin
            state_q    <= StRun;
            fetch_en_q <= 1'b1;
`ifdef PICOBELLO_BOOT_SEQ_TIMEOUT_EN
            wdg_q      <= 32'd0;
`endif
          end
        end

        // EOC wins over a watchdog expiry in the same cycle.
        StRun: begin
          if (eoc_hit_c) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            exit_code_q <= {1'b0, eoc_data_i[31:1]};
          end
`ifdef PICOBELLO_BOOT_SEQ_TIMEOUT_EN
          else if (TimeoutCycles != 32'd0 && (wdg_q + 32'd1) == TimeoutCycles) begin
            state_q     <= StError;
            err_q       <= 1'b1;
            done_q      <= 1'b1;
            exit_code_q <= ExitTimeout;
          end else begin
            wdg_q <= wdg_q + 32'd1;
          end
`endif
        end

        StDone, StError: state_q <= state_q;

        default: state_q <= StIdle;
      endcase
    end
  end

  assign load_req_o  = load_req_q;
  assign fetch_en_o  = fetch_en_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign exit_code_o = exit_code_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_picobello_boot_seq.sv
// -----------------------------------------------------------------------------
// tb_picobello_boot_seq
// Scoreboard bench: the driver pushes the expected observable events (reset
// values, load_req hold length, core release, termination) while a monitor
// detects those events on the DUT outputs and compares them in order.
// -----------------------------------------------------------------------------
module tb_picobello_boot_seq;

  localparam int unsigned TO = 100;
  localparam int unsigned LR = 2;

`ifdef PICOBELLO_BOOT_SEQ_TIMEOUT_EN
  localparam bit WdgOn = 1'b1;
`else
  localparam bit WdgOn = 1'b0;
`endif

  localparam int EvReset = 0;
  localparam int EvReq   = 1;
  localparam int EvFetch = 2;
  localparam int EvDone  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    int          cnt;
    logic [2:0]  st;
    logic        fe;
    logic        dn;
    logic        er;
    logic [31:0] code;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  boot_mode_i = 2'd0;
  logic [1:0]  preload_mode_i = 2'd0;
  logic        preload_done_i = 1'b0;
  logic        load_req_o;
  logic        load_gnt_i = 1'b0;
  logic        load_done_i = 1'b0;
  logic        load_err_i = 1'b0;
  logic        fetch_en_o;
  logic        eoc_valid_i = 1'b0;
  logic [31:0] eoc_data_i = 32'd0;
  logic        done_o;
  logic        err_o;
  logic [31:0] exit_code_o;
  logic [2:0]  state_o;

  picobello_boot_seq #(
    .TimeoutCycles(TO),
    .LoadRetries  (LR)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .boot_mode_i   (boot_mode_i),
    .preload_mode_i(preload_mode_i),
    .preload_done_i(preload_done_i),
    .load_req_o    (load_req_o),
    .load_gnt_i    (load_gnt_i),
    .load_done_i   (load_done_i),
    .load_err_i    (load_err_i),
    .fetch_en_o    (fetch_en_o),
    .eoc_valid_i   (eoc_valid_i),
    .eoc_data_i    (eoc_data_i),
    .done_o        (done_o),
    .err_o         (err_o),
    .exit_code_o   (exit_code_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------- monitor
  int   rel = 0;
  int   rst_cnt = 0;
  int   req_cnt = 0;
  logic prev_req = 1'b0;
  logic prev_fe  = 1'b0;
  logic prev_dn  = 1'b0;

  always @(posedge clk_i) begin
    if (rst_ni) rel <= rel + 1;
    else        rel <= 0;
  end

  function automatic string ev_name(input int k);
    case (k)
      EvReset: return "reset_values";
      EvReq:   return "load_req_hold";
      EvFetch: return "core_release";
      default: return "termination";
    endcase
  endfunction

  task automatic check_ev(input int kind, input int cnt);
    exp_t e;
    bit   ok;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: unexpected event at cycle %0d (st=%0d code=%h)",
               ev_name(kind), rel, state_o, exit_code_o);
      return;
    end
    e  = sb_q.pop_front();
    ok = (e.kind == kind);
    if (kind == EvReq) begin
      ok = ok && (cnt == e.cnt);
    end else begin
      ok = ok && (state_o === e.st) && (fetch_en_o === e.fe) && (done_o === e.dn) &&
           (err_o === e.er) && (exit_code_o === e.code) && (e.cyc < 0 || rel == e.cyc);
      if (kind == EvReset) ok = ok && (load_req_o === 1'b0);
    end
    if (ok) n_pass++;
    else
      $display("FAIL %s: got kind=%0d st=%0d fe=%b dn=%b er=%b code=%h cyc=%0d cnt=%0d req=%b; want kind=%0d st=%0d fe=%b dn=%b er=%b code=%h cyc=%0d cnt=%0d",
               ev_name(kind), kind, state_o, fetch_en_o, done_o, err_o, exit_code_o, rel, cnt,
               load_req_o, e.kind, e.st, e.fe, e.dn, e.er, e.code, e.cyc, e.cnt);
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) rst_cnt = rst_cnt + 1;
    else         rst_cnt = 0;
    if (rst_cnt == 2) check_ev(EvReset, 0);
    if (prev_req && load_req_o !== 1'b1) begin
      check_ev(EvReq, req_cnt);
      req_cnt = 0;
    end
    if (load_req_o === 1'b1) req_cnt = req_cnt + 1;
    prev_req = (load_req_o === 1'b1);
    if (!prev_fe && fetch_en_o === 1'b1) check_ev(EvFetch, 0);
    prev_fe = (fetch_en_o === 1'b1);
    if (!prev_dn && done_o === 1'b1) check_ev(EvDone, 0);
    prev_dn = (done_o === 1'b1);
  end

  // ----------------------------------------------------------------- driver
  int drv_cyc  = 0;
  int pend_req = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
    drv_cyc++;
  endtask

  function automatic void push(input int kind, input int cyc, input int cnt, input logic [2:0] st,
                               input logic fe, input logic dn, input logic er,
                               input logic [31:0] code);
    exp_t e;
    e.kind = kind; e.cyc = cyc; e.cnt = cnt; e.st = st;
    e.fe = fe; e.dn = dn; e.er = er; e.code = code;
    sb_q.push_back(e);
  endfunction

  // Random scratch writes; bit0 may be set (only used outside RUN).
  task automatic junk(input bit allow_eoc);
    logic [31:0] r;
    r = $urandom;
    if (!allow_eoc) r[0] = 1'b0;
    eoc_valid_i = 1'($urandom_range(0, 1));
    eoc_data_i  = r;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    load_gnt_i = 1'b0; load_done_i = 1'b0; load_err_i = 1'b0;
    preload_done_i = 1'b0; eoc_valid_i = 1'b0;
    push(EvReset, -1, -1, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    if (pend_req > 0) begin
      push(EvReq, -1, pend_req, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      pend_req = 0;
    end
    repeat (3) tick();
  endtask

  // One boot from reset. gnt_dly<=0 picks a random grant delay per attempt;
  // abort_d>0 leaves the block in LOAD with the request held abort_d cycles.
  task automatic run_case(input logic [1:0] mode, input logic [1:0] pre, input int pd_at,
                          input int n_err, input int gnt_dly, input int gap,
                          input logic [31:0] eoc, input int abort_d);
    int  d;
    int  budget;
    int  rstart;
    logic [31:0] r;
    do_reset();
    rst_ni = 1'b1; drv_cyc = 0;
    boot_mode_i = mode; preload_mode_i = pre;
    tick(); tick();
    boot_mode_i = 2'($urandom); preload_mode_i = 2'($urandom);

    if (mode == 2'd1) begin
      push(EvDone, 2, -1, 3'd7, 1'b0, 1'b1, 1'b1, 32'hE000_0001);
      repeat (3) tick();
      return;
    end
    if (mode == 2'd0 && pre == 2'd3) begin
      push(EvDone, 2, -1, 3'd7, 1'b0, 1'b1, 1'b1, 32'hE000_0002);
      repeat (3) tick();
      return;
    end

    if (mode == 2'd0) begin
      while (drv_cyc < pd_at) begin junk(1'b1); tick(); end
      preload_done_i = 1'b1; eoc_valid_i = 1'b0;
      push(EvFetch, drv_cyc + 1, -1, 3'd5, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      preload_done_i = 1'b0;
    end else begin
      for (int a = 0; ; a++) begin
        budget = 0;
        while (load_req_o !== 1'b1 && budget < 20) begin tick(); budget++; end
        if (load_req_o !== 1'b1) begin
          n_checks++;
          $display("FAIL load_req_wait: load_req_o=%b after %0d cycles, want 1", load_req_o, budget);
          return;
        end
        if (abort_d > 0) begin
          repeat (abort_d - 1) tick();
          pend_req = abort_d;
          return;
        end
        d = (gnt_dly > 0) ? gnt_dly : int'($urandom_range(1, 4));
        repeat (d - 1) begin junk(1'b1); tick(); end
        load_gnt_i = 1'b1;
        push(EvReq, -1, d, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        load_gnt_i = 1'b0;
        repeat ($urandom_range(0, 2)) begin junk(1'b1); tick(); end
        eoc_valid_i = 1'b0;
        if (a < n_err) begin
          load_err_i  = 1'b1;
          load_done_i = 1'($urandom_range(0, 1));
          if (a >= int'(LR)) begin
            push(EvDone, drv_cyc + 1, -1, 3'd7, 1'b0, 1'b1, 1'b1, 32'hE000_0003);
            tick();
            load_err_i = 1'b0; load_done_i = 1'b0;
            repeat (3) tick();
            return;
          end
          tick();
          load_err_i = 1'b0; load_done_i = 1'b0;
        end else begin
          load_done_i = 1'b1;
          push(EvFetch, drv_cyc + 1, -1, 3'd5, 1'b1, 1'b0, 1'b0, 32'd0);
          tick();
          load_done_i = 1'b0;
          break;
        end
      end
    end

    // Now in the first RUN cycle.
    rstart = drv_cyc;
    if (WdgOn && gap >= int'(TO))
      push(EvDone, rstart + int'(TO), -1, 3'd7, 1'b1, 1'b1, 1'b1, 32'hE000_0004);
    else
      push(EvDone, rstart + gap + 1, -1, 3'd6, 1'b1, 1'b1, 1'b0, eoc >> 1);
    for (int i = 0; i < gap; i++) begin junk(1'b0); tick(); end
    eoc_valid_i = 1'b1; eoc_data_i = eoc;
    tick();
    eoc_valid_i = 1'b0;
    r = $urandom;
    eoc_data_i = r | 32'd1;
    eoc_valid_i = 1'b1;
    repeat (3) tick();
    eoc_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    exp_t        e;
    // Preload via JTAG, preload_done at cycle 10, EOC value 1.
    run_case(2'd0, 2'd0, 10, 0, 0, 3, 32'h0000_0001, 0);
    // Autonomous load, grant after 5 request cycles, exit code 3.
    run_case(2'd2, 2'd1, 0, 0, 5, 2, 32'h0000_0007, 0);
    // Two loader errors recovered; EOC on the first RUN cycle.
    run_case(2'd3, 2'd0, 0, 2, 0, 0, 32'h0000_0BAD, 0);
    // Third loader error exhausts retries.
    run_case(2'd3, 2'd2, 0, 3, 0, 0, 32'h0000_0001, 0);
    // Unsupported SD boot and reserved preload mode.
    run_case(2'd1, 2'd0, 0, 0, 0, 0, 32'h0000_0001, 0);
    run_case(2'd0, 2'd3, 0, 0, 0, 0, 32'h0000_0001, 0);
    // Long RUN with no EOC (watchdog expiry when compiled in).
    run_case(2'd2, 2'd0, 0, 0, 2, 150, 32'h8000_0003, 0);
    // EOC on the 100th RUN cycle.
    run_case(2'd0, 2'd2, 4, 0, 0, int'(TO) - 1, 32'h0000_0011, 0);
    // Reset while LOAD holds its request, then a fresh preload boot.
    run_case(2'd2, 2'd0, 0, 0, 0, 0, 32'h0000_0001, 3);
    run_case(2'd0, 2'd1, 5, 0, 0, 1, 32'hFFFF_FFFF, 0);
    // Random boots.
    for (int k = 0; k < 10; k++) begin
      rnd = $urandom;
      rnd[0] = 1'b1;
      run_case(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), int'($urandom_range(2, 8)),
               int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 5)), rnd, 0);
    end
    do_reset();
    repeat (3) tick();
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      $display("FAIL %s: event never observed, want cyc=%0d cnt=%0d code=%h",
               ev_name(e.kind), e.cyc, e.cnt, e.code);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/picobello_boot_seq.md
PICOBELLO_BOOT_SEQ -- requirements
Module: picobello_boot_seq

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 32'd1048576, meaning run-phase watchdog limit in cycles (0 = watchdog disabled).
REQ-002 SHALL have parameter LoadRetries, default 2, meaning the number of loader re-requests after load_err_i before the sequencer errors out.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port boot_mode_i, input, 2, where 0 = idle/preload, 1 = SD card (unsupported), and 2/3 = autonomous (EEPROM/NOR flash).
REQ-006 SHALL have port preload_mode_i, input, 2, where 0 = JTAG, 1 = serial link, 2 = UART, and 3 = reserved.
REQ-007 SHALL have port preload_done_i, input, 1, a pulse from the external host indicating that the preload has completed.
REQ-008 SHALL have ports load_req_o (output, 1), load_gnt_i (input, 1), load_done_i (input, 1) and load_err_i (input, 1), forming the autonomous image-loader handshake.
REQ-009 SHALL have port fetch_en_o, output, 1, which releases the host core from reset-fetch hold.
REQ-010 SHALL have ports eoc_valid_i (input, 1) and eoc_data_i (input, 32), carrying a scratch-register write observed on the bus.
REQ-011 SHALL have ports done_o (output, 1), err_o (output, 1), exit_code_o (output, 32) and state_o (output, 3).

Function
REQ-012 SHALL implement the FSM states IDLE=0, SAMPLE=1, WAIT_PRE=2, LOAD=3, LOAD_WAIT=4, RUN=5, DONE=6 and ERROR=7, with state_o equal to the current state encoding.
REQ-013 SHALL move IDLE->SAMPLE unconditionally in the first cycle after reset release.
REQ-014 SHALL, in SAMPLE, register boot_mode_i and preload_mode_i once; these registered copies are used thereafter, and later input changes SHALL be ignored until the next reset.
REQ-015 SHALL, in SAMPLE, go to ERROR with exit_code_o=32'hE000_0001 if mode=1, to ERROR with exit_code_o=32'hE000_0002 if mode=0 and preload=3, to WAIT_PRE if mode=0, and to LOAD otherwise.
REQ-016 SHALL, in WAIT_PRE, go to RUN on preload_done_i.
REQ-017 SHALL, in LOAD, assert load_req_o and hold it until the cycle load_gnt_i=1, then go to LOAD_WAIT; load_req_o SHALL NOT drop before the grant.
REQ-018 SHALL, in LOAD_WAIT, go to RUN on load_done_i.
REQ-019 SHALL, in LOAD_WAIT on load_err_i, increment the retry counter and return to LOAD if the counter is below LoadRetries, else go to ERROR with exit_code_o=32'hE000_0003.
REQ-020 SHALL give load_err_i priority when load_done_i and load_err_i are both high in the same cycle.
REQ-021 SHALL register fetch_en_o so that it is 1 exactly while the FSM is in RUN, DONE or ERROR-after-RUN, and it SHALL NOT deassert once set except on reset.
REQ-022 SHALL, in RUN, go to DONE with exit_code_o={1'b0, eoc_data_i[31:1]} when eoc_valid_i=1 and eoc_data_i[0]=1; writes with bit0=0 SHALL be ignored.
REQ-023 SHALL register done_o so that it rises the cycle after the EOC write (one-cycle latency) and stays high; DONE and ERROR SHALL be terminal states until reset.
REQ-024 SHALL, when the first cycle in RUN coincides with an EOC write, accept that EOC.
REQ-025 SHALL register err_o so that it is 1 in ERROR, with done_o also set to 1 in ERROR so that pollers terminate.
REQ-026 SHALL ignore eoc_valid_i outside RUN.

Reset
REQ-027 SHALL, while rst_ni=0 at a clock edge, drive state IDLE, load_req_o=0, fetch_en_o=0, done_o=0, err_o=0, exit_code_o=0, retry counter=0 and watchdog=0.
REQ-028 SHALL, on reset asserted mid-operation in any state, return everything to the values of REQ-027 on the next edge, dropping any outstanding load_req_o without waiting for a grant.

Configuration
REQ-029 SHALL compile the run-phase watchdog only when the macro PICOBELLO_BOOT_SEQ_TIMEOUT_EN is defined.
REQ-030 SHALL, with the watchdog compiled in and TimeoutCycles!=0, clear a 32-bit counter on entry to RUN, increment it each RUN cycle, and go to ERROR with exit_code_o=32'hE000_0004 when it reaches TimeoutCycles.
REQ-031 SHALL give an EOC in the same cycle as the timeout priority, so that the block goes to DONE.
REQ-032 SHALL, without the watchdog compiled in, have no counter, and RUN SHALL wait indefinitely.

Verification
REQ-033 SHALL cover: mode=0, preload=0, preload_done pulse at cycle 10, eoc_data=32'h0000_0001 -> fetch_en_o high, then done_o=1, exit_code_o=0, err_o=0.
REQ-034 SHALL cover: mode=2, grant delayed 5 cycles, load_done, eoc_data=32'h0000_0007 -> load_req_o held 5 cycles, then exit_code_o=3.
REQ-035 SHALL cover: mode=3, load_err twice with LoadRetries=2, then load_done -> RUN reached; a third load_err -> ERROR with exit_code_o=32'hE000_0003.
REQ-036 SHALL cover: mode=1 -> ERROR in 2 cycles with exit_code_o=32'hE000_0001 and fetch_en_o=0; mode=0 with preload=3 -> ERROR with exit_code_o=32'hE000_0002.
REQ-037 SHALL cover: macro defined, TimeoutCycles=100, no EOC -> err_o=1 after 100 RUN cycles with exit_code_o=32'hE000_0004; EOC on cycle 100 -> DONE instead.
REQ-038 SHALL cover: rst_ni low during LOAD with load_req_o high -> all outputs return to zero next edge and the block resamples modes after release.
